instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, is the instruction-memory depth in 32-bit words.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 rx_data  input  8  incoming byte of the load stream.
REQ-006 rx_valid  input  1  rx_data holds a valid byte.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe.
REQ-009 imem_addr  output  10  word index for the write.
REQ-010 imem_wdata  output  32  word to write.
REQ-011 cpu_rst  output  1  holds the processor in reset; high except after a successful load.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 error  output  1  last load aborted (bad length or bad checksum).
REQ-015 words_loaded  output  11  count of words written in the current or last load.

Function
REQ-016 A byte transfers only on a rising edge where rx_valid and rx_ready are both 1.
REQ-017 The FSM has these states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
REQ-018 rx_ready is 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in IDLE, DONE and ERROR.
REQ-019 start in IDLE, DONE or ERROR moves the FSM to LEN_HI on the next edge, clears done, error and words_loaded, and sets cpu_rst to 1.
REQ-020 start in any other state is ignored.
REQ-021 Stream format, in order:
- length N as 16 bits, big-endian (LEN_HI byte, then LEN_LO byte);
- N words of 4 bytes each, big-endian (first byte goes to bits [31:24]);
- one checksum byte.
REQ-022 After the LEN_LO transfer, the FSM goes to ERROR if N is 0 or N > MAX_WORDS; otherwise it goes to DATA.
REQ-023 In DATA, bytes shift into a 32-bit assembly register, and a 2-bit byte counter wraps 3 -> 0.
REQ-024 Write timing:
- imem_we pulses high for exactly one cycle, the cycle after the 4th byte of a word transfers;
- imem_wdata holds the assembled word and imem_addr holds the word index, starting at 0 and incrementing by 1;
- both are held stable after the pulse until the next write.
REQ-025 Byte transfers continue without stall during the imem_we cycle; assembly of the next word proceeds in parallel.
REQ-026 words_loaded increments by 1 on each imem_we pulse.
REQ-027 After the N-th word's 4th byte transfers, the FSM moves to CSUM.
REQ-028 The running checksum is the 8-bit XOR of all data bytes; header bytes are excluded.
REQ-029 On the CSUM transfer, the FSM goes to DONE if the received byte equals the running XOR, else to ERROR; done or error asserts on the following cycle.
REQ-030 cpu_rst is 0 only in DONE; it is 1 in all other states, including ERROR.
REQ-031 busy is 1 in LEN_HI, LEN_LO, DATA and CSUM.
REQ-032 Gaps in rx_valid of any length leave all state unchanged; there is no timeout.
REQ-033 rx_data is ignored whenever the transfer condition of REQ-016 is false.

Reset
REQ-034 rst asserted at any time, including mid-word or mid-header, forces the following immediately:
- FSM to IDLE;
- rx_ready, imem_we, busy, done and error to 0;
- imem_addr, imem_wdata, words_loaded, the checksum and the byte counter to 0;
- cpu_rst to 1.
REQ-035 Words already written before rst remain in instruction memory; the loader performs no rollback.

Verification
REQ-036 Good load: start, then bytes 00 02 20 02 00 04 AC 02 00 04 8C.
- imem_we fires at addr 0 with 0x20020004, then at addr 1 with 0xAC020004;
- words_loaded is 2, done is 1, cpu_rst is 0, error is 0.
REQ-037 Bad checksum: same stream with last byte 8D.
- both words are written;
- error is 1, done is 0, cpu_rst stays 1.
REQ-038 Length 0 (00 00) or length 1025 (04 01): ERROR after the second byte, no imem_we pulse, rx_ready is 0.
REQ-039 Stalled stream: the REQ-036 stream with rx_valid low for 3 cycles between every byte produces identical writes and the same done result.
REQ-040 Reset mid-word: rst after the 2nd data byte of word 1 gives IDLE and cpu_rst=1. A following start with a full 1-word stream (00 01 20 02 00 04 26) then writes addr 0 with 0x20020004 and sets done.
REQ-041 Ignored start: start pulsed while busy leaves the state and words_loaded unchanged; the load completes normally.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: receives a program-load byte stream and writes it into
// instruction memory one 32-bit word at a time.
//
// Stream: 16-bit big-endian word count N, then N big-endian 32-bit words,
// then one checksum byte equal to the XOR of all data bytes.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   start         single-cycle load request (honoured in IDLE, DONE, ERROR)
//   rx_data       incoming stream byte
//   rx_valid      rx_data valid; a byte moves when rx_valid and rx_ready are both 1
//   rx_ready      loader can accept a byte this cycle
//   imem_we       one-cycle write strobe to instruction memory
//   imem_addr     word index of the write (held until the next write)
//   imem_wdata    assembled word (held until the next write)
//   cpu_rst       processor reset, released only after a good load
//   busy          load in progress
//   done          last load finished with a matching checksum
//   error         last load aborted (bad length or bad checksum)
//   words_loaded  words written in the current or last load
//
// state  | meaning
// IDLE   | waiting for start after reset
// LEN_HI | expecting high byte of word count
// LEN_LO | expecting low byte of word count, then range check
// DATA   | assembling and writing words
// CSUM   | expecting checksum byte
// DONE   | load good, processor released
// ERROR  | load aborted, processor held in reset

module instr_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, next_state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [23:0] asm_word;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;

  logic        xfer;
  logic        load_start;
  logic [15:0] len_full;
  logic        len_bad;
  logic        word_done;
  logic        last_word;

  assign xfer       = rx_valid && rx_ready;
  assign load_start = start && (state == IDLE || state == DONE || state == ERROR);
  assign len_full   = {len_hi, rx_data};
  assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
  assign word_done  = (state == DATA) && xfer && (byte_cnt == 2'd3);
  // words_loaded still counts prior words when the final byte of a word arrives
  assign last_word  = ({5'd0, words_loaded} == (len - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_rst    = 1'b1;
    case (state)
      IDLE: begin
        if (start) next_state = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) next_state = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) next_state = len_bad ? ERROR : DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (word_done && last_word) next_state = CSUM;
      end
      CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) next_state = (rx_data == csum) ? DONE : ERROR;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) next_state = LEN_HI;
      end
      ERROR: begin
        error = 1'b1;
        if (start) next_state = LEN_HI;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi       <= 8'd0;
      len          <= 16'd0;
      asm_word     <= 24'd0;
      byte_cnt     <= 2'd0;
      csum         <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= 10'd0;
      imem_wdata   <= 32'd0;
      words_loaded <= 11'd0;
    end else begin
      imem_we <= 1'b0;
      if (load_start) begin
        words_loaded <= 11'd0;
        byte_cnt     <= 2'd0;
        csum         <= 8'd0;
      end
      if (state == LEN_HI && xfer) len_hi <= rx_data;
      if (state == LEN_LO && xfer) len    <= len_full;
      if (state == DATA && xfer) begin
        asm_word <= {asm_word[15:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
        csum     <= csum ^ rx_data;
        if (byte_cnt == 2'd3) begin
          imem_we      <= 1'b1;
          imem_wdata   <= {asm_word, rx_data};
          imem_addr    <= words_loaded[9:0];
          words_loaded <= words_loaded + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  instr_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // captured writes
  logic [9:0]  got_addr[$];
  logic [31:0] got_data[$];
  int          we_double = 0;
  logic        we_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      if (we_prev) we_double++;
    end
    we_prev = imem_we;
  end

  // reference model results
  logic [7:0]  stream[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_words;
  int          send_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    n = {stream[0], stream[1]};
    x = 8'd0;
    if (n == 0 || n > 1024) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_words = 0; send_len = 2;
    end else begin
      for (int w = 0; w < n; w++) begin
        exp_addr.push_back(w[9:0]);
        exp_data.push_back({stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
        for (int k = 0; k < 4; k++) x = x ^ stream[2+4*w+k];
      end
      exp_words = n;
      exp_done  = (stream[2+4*n] == x);
      exp_err   = !exp_done;
      send_len  = 2 + 4*n + 1;
    end
  endtask

  task automatic build_random(input int n, input bit good);
    logic [7:0] x, b;
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
    x = 8'd0;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      stream.push_back(b);
      x = x ^ b;
    end
    stream.push_back(good ? x : (x ^ 8'(1 << $urandom_range(7, 0))));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      start = 1'b0; rx_valid = 1'b0; rx_data = 8'($urandom);
    end
    @(negedge clk);
    start = inj; rx_valid = 1'b1; rx_data = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (t >= 50) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; rx_valid = 1'b0;
  endtask

  task automatic run_load(input string name, input int gmin, input int gmax, input bit inject);
    got_addr.delete();
    got_data.delete();
    we_double = 0;
    model();
    pulse_start();
    for (int i = 0; i < send_len; i++)
      send_byte(stream[i], $urandom_range(gmax, gmin), inject && ($urandom_range(3, 0) == 0));
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    check({name, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({name, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
      check({name, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
    end
    check({name, "_words"}, 64'(words_loaded), 64'(exp_words));
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({name, "_we_width"}, 64'(we_double), 64'd0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({name, "_we"}, 64'(imem_we), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_error"}, 64'(error), 64'd0);
    check({name, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({name, "_addr"}, 64'(imem_addr), 64'd0);
    check({name, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({name, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("idle");

    stream = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h04, 8'h8C};
    run_load("good", 0, 0, 1'b0);
    check("good_w1", 64'(got_data.size() > 1 ? got_data[1] : 32'd0), 64'hAC020004);

    stream = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h04, 8'h8D};
    run_load("badcsum", 0, 0, 1'b0);

    stream = '{8'h00, 8'h00};
    run_load("len0", 0, 1, 1'b0);

    stream = '{8'h04, 8'h01};
    run_load("len1025", 0, 1, 1'b0);

    stream = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h04, 8'h8C};
    run_load("stall", 3, 3, 1'b0);
    check("stall_w0", 64'(got_data.size() > 0 ? got_data[0] : 32'd0), 64'h20020004);

    stream = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h04, 8'h8C};
    run_load("ignstart", 0, 2, 1'b1);

    // reset in the middle of word 1
    got_addr.delete();
    got_data.delete();
    pulse_start();
    stream = '{8'h00, 8'h02, 8'h20, 8'h02, 8'h00, 8'h04, 8'hAC, 8'h02};
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i], 0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_state("midrst");
    check("midrst_prior_writes", 64'(got_addr.size()), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    stream = '{8'h00, 8'h01, 8'h20, 8'h02, 8'h00, 8'h04, 8'h26};
    run_load("after_rst", 0, 0, 1'b0);

    // randomized loads
    for (int r = 0; r < 12; r++) begin
      build_random($urandom_range(6, 1), $urandom_range(3, 0) != 0);
      run_load("rand", 0, 3, 1'b1);
    end

    // maximum legal length
    build_random(1024, 1'b1);
    run_load("len1024", 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
